// File: rtl/async_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_rd_ctrl
// Read-side controller of the dual-clock FIFO. Owns the binary/gray read
// pointer, the registered empty / almost-empty flags and the read-side
// occupancy count, and drives the FIFO memory read address and strobe.
// Everything runs on rd_clk; wr_ptr_rsync arrives already synchronized.
//
// Optional feature: define ASYNC_FIFO_FWFT_EN to compile in a two-entry
// first-word-fall-through stage (output register + skid register).
//
// Ports:
//   rd_clk        in   read-domain clock (rising edge)
//   rst           in   synchronous active-high reset
//   rd_en         in   pop request (FWFT: consume rd_data)
//   wr_ptr_rsync  in   gray write pointer, synchronized to rd_clk
//   rd_addr       out  memory read address (low bits of binary read pointer)
//   mem_rd_en     out  memory read strobe (internal pop)
//   rd_ptr        out  registered gray read pointer for the write domain
//   rd_empty      out  empty flag
//   rd_aempty     out  registered almost-empty flag
//   rd_count      out  registered pointer occupancy 0..DEPTH
//   mem_rdata     in   memory data, one cycle after mem_rd_en (FWFT only)
//   rd_data       out  head-of-FIFO data (FWFT only)
//   rd_valid      out  rd_data valid (FWFT only)
// -----------------------------------------------------------------------------
module async_rd_ctrl #(
  parameter int DEPTH         = 4,
  parameter int DWIDTH        = 32,
  parameter int AEMPTY_THRESH = 1,
  localparam int AWIDTH       = $clog2(DEPTH)
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AWIDTH:0]   wr_ptr_rsync,
  output logic [AWIDTH-1:0] rd_addr,
  output logic              mem_rd_en,
  output logic [AWIDTH:0]   rd_ptr,
  output logic              rd_empty,
  output logic              rd_aempty,
`ifdef ASYNC_FIFO_FWFT_EN
  output logic [AWIDTH:0]   rd_count,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
`else
  output logic [AWIDTH:0]   rd_count
`endif
);

  localparam logic [AWIDTH:0] AE_TH = (AWIDTH + 1)'(AEMPTY_THRESH);

  // Parameter sanity, resolved at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DWIDTH < 1) ||
      (AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_param_chk
    $error("async_rd_ctrl: illegal parameter set");
  end

  function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
    logic [AWIDTH:0] b;
    b[AWIDTH] = g[AWIDTH];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AWIDTH:0] rd_bin_r;
  logic            e_int_r;
  logic            pop_s;
  logic [AWIDTH:0] wr_bin_s;
  logic [AWIDTH:0] rd_bin_next_s;
  logic [AWIDTH:0] occ_s;

  // Pointer arithmetic shared by both build variants.
  always_comb begin
    wr_bin_s      = gray2bin(wr_ptr_rsync);
    rd_bin_next_s = rd_bin_r + {{AWIDTH{1'b0}}, pop_s};
    occ_s         = wr_bin_s - rd_bin_next_s;
  end

  // Read pointer, internal empty and occupancy-derived flags.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_bin_r  <= '0;
      rd_ptr    <= '0;
      e_int_r   <= 1'b1;
      rd_count  <= '0;
      rd_aempty <= 1'b1;
    end else begin
      rd_bin_r  <= rd_bin_next_s;
      rd_ptr    <= bin2gray(rd_bin_next_s);
      e_int_r   <= (rd_bin_next_s == wr_bin_s);
      rd_count  <= occ_s;
      rd_aempty <= (occ_s <= AE_TH);
    end
  end

  assign rd_addr   = rd_bin_r[AWIDTH-1:0];
  assign mem_rd_en = pop_s;

`ifdef ASYNC_FIFO_FWFT_EN
  logic [1:0]        held_r;   // words in output+skid registers
  logic              pend_r;   // pop issued last cycle, data arrives now
  logic [DWIDTH-1:0] skid_r;
  logic              consume_s;
  logic [1:0]        held_after_s;
  logic [2:0]        fill_s;

  // Prefetch control: pop only while the buffer can absorb the word.
  always_comb begin
    consume_s    = rd_en & rd_valid;
    held_after_s = held_r - {1'b0, consume_s};
    fill_s       = {1'b0, held_r} + {2'b00, pend_r} - {2'b00, consume_s};
    pop_s        = ~e_int_r & (fill_s <= 3'd1);
  end

  // Output/skid data registers and their occupancy.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      held_r  <= 2'd0;
      pend_r  <= 1'b0;
      rd_data <= '0;
      skid_r  <= '0;
    end else begin
      held_r <= held_after_s + {1'b0, pend_r};
      pend_r <= pop_s;
      // Skid advances on consume; an arriving word lands in whichever
      // register is the first free one after that move.
      if (consume_s && (held_r == 2'd2)) begin
        rd_data <= skid_r;
      end
      if (pend_r) begin
        case (held_after_s)
          2'd0:    rd_data <= mem_rdata;
          2'd1:    skid_r  <= mem_rdata;
          default: skid_r  <= skid_r;
        endcase
      end
    end
  end

  assign rd_valid = (held_r != 2'd0);
  assign rd_empty = ~rd_valid;
`else
  // Plain mode: pop straight from the memory on request.
  always_comb begin
    pop_s = rd_en & ~e_int_r;
  end

  assign rd_empty = e_int_r;
`endif

endmodule

// File: doc/async_rd_ctrl.md
# async_rd_ctrl

Read-side control for the dual-clock FIFO in the traffic engine's easy_fifo library; the counterpart of the write-side controller. Owns the gray-coded read pointer, the registered empty/almost-empty flags and the read-side occupancy count, and drives the FIFO memory read address. Sits entirely in the `rd_clk` domain. Its inputs are the write pointer, already synchronized into `rd_clk` by the FIFO's 2-FF synchronizer, and the memory read data. An optional first-word-fall-through (FWFT) output stage is available.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2. `AWIDTH` = $clog2(DEPTH).
- `DWIDTH`, 32: data width; used only with FWFT.
- `AEMPTY_THRESH`, 1: `rd_aempty` asserts when occupancy ≤ this value; range 0..DEPTH-1.

Ports:
- `rd_clk`  in  1  read-domain clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  read request (non-FWFT: pop; FWFT: consume `rd_data`).
- `wr_ptr_rsync`  in  AWIDTH+1  gray write pointer, synchronized to `rd_clk`.
- `rd_addr`  out  AWIDTH  binary memory read address = low bits of the binary read pointer.
- `mem_rd_en`  out  1  memory read strobe; equals internal pop.
- `rd_ptr`  out  AWIDTH+1  registered gray read pointer, sent to the write-domain synchronizer.
- `rd_empty`  out  1  registered empty flag.
- `rd_aempty`  out  1  registered almost-empty flag.
- `rd_count`  out  AWIDTH+1  registered pointer occupancy, 0..DEPTH.
- `mem_rdata`  in  DWIDTH  memory data, valid one cycle after `mem_rd_en` (FWFT only).
- `rd_data`  out  DWIDTH  head-of-FIFO data (FWFT only).
- `rd_valid`  out  1  `rd_data` valid (FWFT only).

## Operation
- Binary/gray pointers are AWIDTH+1 bits and wrap modulo 2^(AWIDTH+1). Bit AWIDTH is the lap bit.
- Internal empty `e_int`: registered. Next value = (rd_bin + pop) == gray2bin(`wr_ptr_rsync`).
- Occupancy arithmetic: `wr_bin` − `rd_bin_next`, modulo 2^(AWIDTH+1).
- `rd_count` <= occupancy. It counts pointer occupancy only and never includes FWFT-buffered words.
- `rd_aempty` <= occupancy ≤ `AEMPTY_THRESH`.
- The `rd_ptr` gray register is single-bit-change per increment; it never glitches to the write domain.
- Non-FWFT:
  - pop = `rd_en` & ~`e_int`.
  - `rd_empty` = `e_int`.
  - Memory data appears one cycle after pop; the user reads the memory port directly.
  - `rd_en` while empty is ignored; the pointer is held.
- FWFT: 2-entry prefetch buffer (output register + skid register).
  - State: `held` (0..2) and `pend` (pop issued last cycle).
  - consume = `rd_en` & `rd_valid`. `rd_en` without `rd_valid` is ignored.
  - pop = ~`e_int` & ((`held` + `pend` − consume) ≤ 1).
  - Arriving `mem_rdata` loads the output register if it will be empty after consume; otherwise it loads the skid register.
  - On consume with skid full, skid moves to output in the same edge.
  - Output order is strict FIFO order.
  - `rd_valid` = output register full. `rd_empty` = ~`rd_valid`.
- Reset values:
  - Pointers 0; `rd_ptr` 0.
  - `rd_empty` 1, `rd_aempty` 1, `rd_count` 0, `mem_rd_en` 0.
  - `held` 0, `pend` 0, `rd_valid` 0, `rd_data` 0.
- Reset mid-operation discards buffered words and pending reads. The write side must be reset in the same window.

## Timing
- `wr_ptr_rsync` changes before edge E → `e_int`, `rd_empty` (non-FWFT), `rd_count` and `rd_aempty` update at E.
- Pop in cycle C → `rd_ptr` advances at edge C+1 and flags reflect it at C+1. No pop → flags update within 1 cycle of new `wr_ptr_rsync`.
- FWFT first-word latency:
  - `e_int` falls at E; `mem_rd_en` high in cycle E→E+1; `rd_valid` rises at E+2.
- FWFT throughput is 1 word/cycle sustained with `rd_en` held high.
- Wrap: pointer 2^(AWIDTH+1)−1 → 0 with no flag disturbance.
- Full-FIFO read: `rd_count` = DEPTH with lap bits differing; the first pop gives DEPTH−1.

## Configuration
- `ASYNC_FIFO_FWFT_EN` defined:
  - FWFT stage, `mem_rdata`, `rd_data` and `rd_valid` are compiled in.
  - `rd_empty` = ~`rd_valid`.
- `ASYNC_FIFO_FWFT_EN` undefined:
  - Those three ports are absent; pop = `rd_en` & ~`e_int`; `rd_empty` = `e_int`.

## Test plan
- Reset with `wr_ptr_rsync`=0, DEPTH=4 → `rd_empty`=1, `rd_aempty`=1, `rd_count`=0, `rd_ptr`=0; `rd_en`=1 for 5 cycles → `rd_ptr` stays 0 and `mem_rd_en` stays 0.
- `wr_ptr_rsync` = gray(4) (full), non-FWFT, `rd_en`=1 for 5 cycles → `rd_addr` 0,1,2,3; `rd_count` 4→3→2→1→0; `rd_aempty` rises at count 1; `rd_empty` rises after the 4th pop; the 5th request is ignored.
- Pointer wrap: 20 write/read pairs at DEPTH=4 → `rd_ptr` goes gray 7 → gray 0 with `rd_empty` correct throughout.
- FWFT: 3 words D0..D2 available, `rd_en`=0 → `rd_valid`=1 at E+2 with `rd_data`=D0, `held`=2, third word not popped; then `rd_en`=1 → D0, D1, D2 on consecutive cycles, then `rd_valid`=0.
- FWFT with random `rd_en` and random `wr_ptr_rsync` advances over 10k cycles → scoreboard shows order preserved, no loss or duplicate, `held`+`pend` never exceeds 2.
- `rst` asserted mid-stream with `held`=2 → next cycle `rd_valid`=0, `rd_ptr`=0, `rd_empty`=1.
